// File: rtl/top_bus_arb.sv
// Two-master round-robin arbiter for the top-level bus: one transfer in flight,
// per-transfer slave timeout that turns a silent slave into an error response.
module top_bus_arb #(
  parameter int addrwidth_p = 32,
  parameter int datawidth_p = 32,
  parameter int timeout_p   = 16
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_i,
  input  logic [1:0]             m0_bus_trans_i,
  input  logic [addrwidth_p-1:0] m0_bus_addr_i,
  input  logic                   m0_bus_write_i,
  input  logic [datawidth_p-1:0] m0_bus_wdata_i,
  output logic                   m0_bus_ready_o,
  output logic                   m0_bus_resp_o,
  output logic [datawidth_p-1:0] m0_bus_rdata_o,
  input  logic [1:0]             m1_bus_trans_i,
  input  logic [addrwidth_p-1:0] m1_bus_addr_i,
  input  logic                   m1_bus_write_i,
  input  logic [datawidth_p-1:0] m1_bus_wdata_i,
  output logic                   m1_bus_ready_o,
  output logic                   m1_bus_resp_o,
  output logic [datawidth_p-1:0] m1_bus_rdata_o,
  output logic [1:0]             s_bus_trans_o,
  output logic [addrwidth_p-1:0] s_bus_addr_o,
  output logic                   s_bus_write_o,
  output logic [datawidth_p-1:0] s_bus_wdata_o,
  input  logic                   s_bus_ready_i,
  input  logic                   s_bus_resp_i,
  input  logic [datawidth_p-1:0] s_bus_rdata_i,
  output logic                   grant_o,
  output logic                   busy_o
);

  localparam int cnt_w_lp = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);
  localparam bit to_en_lp = (timeout_p != 0);
  // With the timeout disabled the counter just parks at all-ones.
  localparam logic [cnt_w_lp-1:0] cnt_max_lp =
    (timeout_p == 0) ? {cnt_w_lp{1'b1}} : cnt_w_lp'(timeout_p - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q;
  logic [cnt_w_lp-1:0]   cnt_q;
  logic                  req0, req1;
  logic                  start, grant_sel, done, abort;

  assign req0   = |m0_bus_trans_i;
  assign req1   = |m1_bus_trans_i;
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Arbitration and completion decode; slave ready is only honoured in XFER.
  always_comb begin
    start     = 1'b0;
    grant_sel = grant_o;
    if (state_q == IDLE) begin
      if (req0 && req1) begin
        start     = 1'b1;
        grant_sel = ~last_grant_q;
      end else if (req0) begin
        start     = 1'b1;
        grant_sel = 1'b0;
      end else if (req1) begin
        start     = 1'b1;
        grant_sel = 1'b1;
      end
    end
    done  = (state_q == XFER) && s_bus_ready_i;
    abort = (state_q == XFER) && !s_bus_ready_i && to_en_lp && (cnt_q == cnt_max_lp);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = XFER;
      XFER:    if (done || abort) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      last_grant_q   <= 1'b1;
      grant_o        <= 1'b0;
      cnt_q          <= '0;
      s_bus_trans_o  <= 2'b00;
      s_bus_addr_o   <= '0;
      s_bus_write_o  <= 1'b0;
      s_bus_wdata_o  <= '0;
      m0_bus_ready_o <= 1'b0;
      m0_bus_resp_o  <= 1'b0;
      m0_bus_rdata_o <= '0;
      m1_bus_ready_o <= 1'b0;
      m1_bus_resp_o  <= 1'b0;
      m1_bus_rdata_o <= '0;
    end else begin
      m0_bus_ready_o <= 1'b0;
      m0_bus_resp_o  <= 1'b0;
      m0_bus_rdata_o <= '0;
      m1_bus_ready_o <= 1'b0;
      m1_bus_resp_o  <= 1'b0;
      m1_bus_rdata_o <= '0;
      case (state_q)
        IDLE: if (start) begin
          grant_o       <= grant_sel;
          cnt_q         <= '0;
          s_bus_trans_o <= grant_sel ? m1_bus_trans_i : m0_bus_trans_i;
          s_bus_addr_o  <= grant_sel ? m1_bus_addr_i  : m0_bus_addr_i;
          s_bus_write_o <= grant_sel ? m1_bus_write_i : m0_bus_write_i;
          s_bus_wdata_o <= grant_sel ? m1_bus_wdata_i : m0_bus_wdata_i;
        end
        XFER: begin
          if (cnt_q != cnt_max_lp) cnt_q <= cnt_q + 1'b1;
          // Response goes straight into the granted master's output registers.
          if (done || abort) begin
            s_bus_trans_o <= 2'b00;
            if (grant_o) begin
              m1_bus_ready_o <= 1'b1;
              m1_bus_resp_o  <= done ? s_bus_resp_i  : 1'b1;
              m1_bus_rdata_o <= done ? s_bus_rdata_i : '0;
            end else begin
              m0_bus_ready_o <= 1'b1;
              m0_bus_resp_o  <= done ? s_bus_resp_i  : 1'b1;
              m0_bus_rdata_o <= done ? s_bus_rdata_i : '0;
            end
          end
        end
        RESP:    last_grant_q <= grant_o;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_bus_arb.sv
// Directed bench for top_bus_arb: reset, single read, round-robin writes,
// delayed slave, timeout abort, ready-at-expiry and reset mid-transfer.
module tb_top_bus_arb;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m0_trans, m1_trans;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_write, m1_write;
  logic        m0_ready, m0_resp, m1_ready, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  s_trans;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_write, s_ready, s_resp;
  logic        grant, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  top_bus_arb #(.addrwidth_p(32), .datawidth_p(32), .timeout_p(TO)) dut (
    .main_clk_i(clk), .main_rst_i(rst),
    .m0_bus_trans_i(m0_trans), .m0_bus_addr_i(m0_addr), .m0_bus_write_i(m0_write),
    .m0_bus_wdata_i(m0_wdata), .m0_bus_ready_o(m0_ready), .m0_bus_resp_o(m0_resp),
    .m0_bus_rdata_o(m0_rdata),
    .m1_bus_trans_i(m1_trans), .m1_bus_addr_i(m1_addr), .m1_bus_write_i(m1_write),
    .m1_bus_wdata_i(m1_wdata), .m1_bus_ready_o(m1_ready), .m1_bus_resp_o(m1_resp),
    .m1_bus_rdata_o(m1_rdata),
    .s_bus_trans_o(s_trans), .s_bus_addr_o(s_addr), .s_bus_write_o(s_write),
    .s_bus_wdata_o(s_wdata), .s_bus_ready_i(s_ready), .s_bus_resp_i(s_resp),
    .s_bus_rdata_i(s_rdata), .grant_o(grant), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_trans = 2'b00; m0_addr = '0; m0_write = 1'b0; m0_wdata = '0;
    m1_trans = 2'b00; m1_addr = '0; m1_write = 1'b0; m1_wdata = '0;
    s_ready = 1'b0; s_resp = 1'b0; s_rdata = '0;
    tick(); tick();
    chk("rst_s_trans", s_trans, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    rst = 1'b0;
    tick();

    // Single read from master 0, slave answers in the first XFER cycle.
    m0_trans = 2'b10; m0_addr = 32'h0000_0100; m0_write = 1'b0;
    tick();
    chk("rd_c1_s_trans", s_trans, 2'b10);
    chk("rd_c1_s_addr", s_addr, 32'h0000_0100);
    chk("rd_c1_busy", busy, 1);
    chk("rd_c1_grant", grant, 0);
    chk("rd_c1_m0_ready", m0_ready, 0);
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_c2_m0_ready", m0_ready, 1);
    chk("rd_c2_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_m0_resp", m0_resp, 0);
    chk("rd_c2_m1_ready", m1_ready, 0);
    chk("rd_c2_m1_rdata", m1_rdata, 0);
    chk("rd_c2_s_trans", s_trans, 0);
    m0_trans = 2'b00; s_ready = 1'b0; s_rdata = '0;
    tick();
    chk("rd_c3_m0_ready", m0_ready, 0);
    chk("rd_c3_busy", busy, 0);

    // Both masters write continuously; last grant was 0, so 1,0,1,0.
    m0_trans = 2'b11; m0_addr = 32'hA000_0000; m0_write = 1'b1; m0_wdata = 32'h1111_0000;
    m1_trans = 2'b11; m1_addr = 32'hB000_0004; m1_write = 1'b1; m1_wdata = 32'h2222_0001;
    s_ready = 1'b1; s_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 0);
      tick();
      chk("rr_grant", grant, g);
      chk("rr_s_addr", s_addr, g ? 32'hB000_0004 : 32'hA000_0000);
      chk("rr_s_wdata", s_wdata, g ? 32'h2222_0001 : 32'h1111_0000);
      chk("rr_s_write", s_write, 1);
      tick();
      chk("rr_m0_ready", m0_ready, !g);
      chk("rr_m1_ready", m1_ready, g);
      tick();
      chk("rr_idle_busy", busy, 0);
    end
    m0_trans = 2'b00; m1_trans = 2'b00; s_ready = 1'b0;
    tick();

    // Slave ready delayed to cycle 5.
    m0_trans = 2'b10; m0_addr = 32'h0000_0200; m0_write = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("dly_s_trans", s_trans, 2'b10);
      chk("dly_m0_ready", m0_ready, 0);
    end
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'h1234_5678;
    tick();
    chk("dly_c6_m0_ready", m0_ready, 1);
    chk("dly_c6_m0_rdata", m0_rdata, 32'h1234_5678);
    m0_trans = 2'b00; s_ready = 1'b0;
    tick();

    // Slave never answers: abort at cycle TO+1 with error and zero data.
    m1_trans = 2'b01; m1_addr = 32'h0000_0300; m1_write = 1'b0;
    s_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= TO; c++) begin
      tick();
      chk("to_s_trans", s_trans, 2'b01);
      chk("to_m1_ready", m1_ready, 0);
    end
    tick();
    chk("to_m1_ready_end", m1_ready, 1);
    chk("to_m1_resp", m1_resp, 1);
    chk("to_m1_rdata", m1_rdata, 0);
    chk("to_s_trans_end", s_trans, 0);
    chk("to_m0_ready", m0_ready, 0);
    m1_trans = 2'b00;
    tick();
    chk("to_idle_busy", busy, 0);
    m0_trans = 2'b01; m0_addr = 32'h0000_0400; m0_write = 1'b1; m0_wdata = 32'h5555_AAAA;
    tick();
    chk("post_to_grant", grant, 0);
    chk("post_to_s_wdata", s_wdata, 32'h5555_AAAA);
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'h0000_0000;
    tick();
    chk("post_to_m0_ready", m0_ready, 1);
    chk("post_to_m0_resp", m0_resp, 0);
    m0_trans = 2'b00; s_ready = 1'b0;
    tick();

    // Slave ready in the very cycle the timeout would fire: slave wins.
    m0_trans = 2'b10; m0_addr = 32'h0000_0500; m0_write = 1'b0;
    for (int c = 1; c < TO; c++) tick();
    tick();
    chk("edge_c6_m0_ready", m0_ready, 0);
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'hCAFE_F00D;
    tick();
    chk("edge_m0_ready", m0_ready, 1);
    chk("edge_m0_resp", m0_resp, 0);
    chk("edge_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    m0_trans = 2'b00; s_ready = 1'b0;
    tick();

    // Reset during the second XFER cycle of a master 1 transfer.
    m1_trans = 2'b10; m1_addr = 32'h0000_0600; m1_write = 1'b0;
    tick();
    tick();
    chk("mid_pre_grant", grant, 1);
    chk("mid_pre_s_trans", s_trans, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_s_trans", s_trans, 0);
    chk("mid_rst_s_addr", s_addr, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    chk("mid_rst_m1_ready", m1_ready, 0);
    rst = 1'b0;
    m0_trans = 2'b10; m0_addr = 32'h0000_0700; m0_write = 1'b0;
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'h0BAD_CAFE;
    tick();
    chk("after_rst_grant", grant, 0);
    chk("after_rst_s_addr", s_addr, 32'h0000_0700);
    tick();
    chk("after_rst_m0_ready", m0_ready, 1);
    chk("after_rst_m1_ready", m1_ready, 0);
    m0_trans = 2'b00;
    tick();
    chk("stray_ready_m1", m1_ready, 0);
    chk("stray_ready_m0", m0_ready, 0);
    tick();
    chk("m1_alone_grant", grant, 1);
    chk("m1_alone_s_addr", s_addr, 32'h0000_0600);
    tick();
    chk("m1_alone_ready", m1_ready, 1);
    chk("m1_alone_rdata", m1_rdata, 32'h0BAD_CAFE);
    m1_trans = 2'b00; s_ready = 1'b0;
    tick();
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
